oversampling_period_generator: RTL and testbench

// Synthesises a square wave with a programmable period at sub-CLK resolution
// (1/2^OVERSAMPLING_BITS of a CLK cycle) as a parallel sample word per CLK, earliest slot in bit 0.

---
 rtl/theremin_sensor_pkg.sv | 24 ++
 rtl/period_word_shaper.sv | 34 +++
 rtl/oversampling_period_generator.sv | 142 ++++++++++++++
 tb/tb_oversampling_period_generator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/theremin_sensor_pkg.sv
// Shared types and sizing helpers for the theremin sensor transmit/measure pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package theremin_sensor_pkg;

  // Generator control states: stopped, driving the high half, driving the low half.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } gen_state_t;

  // Number of sub-CLK slots carried in one parallel sample word.
  function automatic int unsigned slots_per_clk(input int unsigned os_bits);
    return 32'd1 << os_bits;
  endfunction

  // Width of a period/duration value in slots (integer CLK part + slot fraction).
  function automatic int unsigned period_width(input int unsigned counter_bits,
                                               input int unsigned os_bits);
    return counter_bits + os_bits;
  endfunction

endpackage

// File: rtl/period_word_shaper.sv
// Builds one sample word: first rem_i slots at level_i, remaining slots at the opposite level.
// Latency: combinational.
// Backpressure: none.
// Ports: level_i   level of the current half
//        rem_i     slots left in the current half at word start (>= S means whole word)
//        kill_tail_i  force slots after the toggle to 0 (stopping at the end of a period)
//        prev_msb_i   last slot of the previous word, for edge detection across words
//        word_o    sample word, bit 0 earliest; edge_o 1 if the word contains a rising edge
module period_word_shaper #(
  parameter int unsigned S  = 8,
  parameter int unsigned RW = 16
) (
  input  logic          level_i,
  input  logic [RW-1:0] rem_i,
  input  logic          kill_tail_i,
  input  logic          prev_msb_i,
  output logic [S-1:0]  word_o,
  output logic          edge_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < int'(S); i++) begin
      if (int'(rem_i) > i) word_o[i] = level_i;
      else                 word_o[i] = ~level_i & ~kill_tail_i;
    end
    // Rising edge either at the word boundary or between two adjacent slots.
    edge_o = word_o[0] & ~prev_msb_i;
    for (int i = 0; i < int'(S) - 1; i++) begin
      if (!word_o[i] && word_o[i+1]) edge_o = 1'b1;
    end
  end

endmodule

// File: rtl/oversampling_period_generator.sv
// Square-wave generator with slot-resolution period, one S-slot sample word per CLK for an OSERDES.
// Latency: 1 CLK from internal state to SAMPLES_OUT/EDGE_FLAG (registered outputs).
// Backpressure: none; PERIOD_WR is fire-and-forget, last write before a rising edge wins.
// Ports: CLK, RESET (sync, active high), ENABLE (stop is glitch-free at end of period),
//        PERIOD_IN/PERIOD_WR (period in slots, clamped to >= 2*S), SAMPLES_OUT (bit 0 earliest),
//        EDGE_FLAG (word holds a rising edge), BUSY (generator not idle).
module oversampling_period_generator
  import theremin_sensor_pkg::*;
#(
  parameter int unsigned COUNTER_BITS      = 12,
  parameter int unsigned OVERSAMPLING_BITS = 3,
  localparam int unsigned S = slots_per_clk(OVERSAMPLING_BITS),
  localparam int unsigned W = period_width(COUNTER_BITS, OVERSAMPLING_BITS)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         ENABLE,
  input  logic [W-1:0] PERIOD_IN,
  input  logic         PERIOD_WR,
  output logic [S-1:0] SAMPLES_OUT,
  output logic         EDGE_FLAG,
  output logic         BUSY
);

  localparam int unsigned    RW         = W + 1;
  localparam logic [W-1:0]  MIN_PERIOD = W'(2 * S);
  localparam logic [RW-1:0] S_R        = RW'(S);

  gen_state_t    state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [W-1:0]  pend_q, pend_d;
  logic [W-1:0]  act_q, act_d;
  logic          stop_q, stop_d;
  logic [S-1:0]  samples_q, samples_d;
  logic          edge_q, edge_d;

  // Halves: high gets floor(P/2), low gets the rest (odd periods have the longer low).
  logic [W-1:0]  act_high, act_low, pend_high;
  assign act_high  = act_q >> 1;
  assign act_low   = act_q - act_high;
  assign pend_high = pend_q >> 1;

  logic          level, toggle, kill_tail, shaped_edge;
  logic [RW-1:0] gap;
  logic [S-1:0]  shaped;

  always_comb begin
    level  = (state_q == HIGH);
    // The current half ends inside (or exactly at the end of) this word.
    toggle = (state_q != IDLE) && (rem_q <= S_R);
    // Slots of the new half already consumed in this word; only used when toggling.
    gap    = S_R - rem_q;
    // A stop request survives until the end of the period unless ENABLE returns during LOW.
    stop_d = stop_q;
    if (state_q == IDLE)     stop_d = 1'b0;
    else if (!ENABLE)        stop_d = 1'b1;
    else if (state_q == LOW) stop_d = 1'b0;
    kill_tail = (state_q == LOW) && toggle && stop_d;
  end

  period_word_shaper #(.S(S), .RW(RW)) u_shaper (
    .level_i     (level),
    .rem_i       (rem_q),
    .kill_tail_i (kill_tail),
    .prev_msb_i  (samples_q[S-1]),
    .word_o      (shaped),
    .edge_o      (shaped_edge)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    act_d     = act_q;
    pend_d    = pend_q;
    samples_d = '0;
    edge_d    = 1'b0;

    if (PERIOD_WR) pend_d = (PERIOD_IN < MIN_PERIOD) ? MIN_PERIOD : PERIOD_IN;

    case (state_q)
      IDLE: begin
        if (ENABLE) begin
          state_d = HIGH;
          act_d   = pend_q;
          rem_d   = RW'(pend_high);
        end
      end
      HIGH: begin
        samples_d = shaped;
        edge_d    = shaped_edge;
        if (toggle) begin
          state_d = LOW;
          rem_d   = RW'(act_low) - gap;
        end else begin
          rem_d   = rem_q - S_R;
        end
      end
      LOW: begin
        samples_d = shaped;
        edge_d    = shaped_edge;
        if (toggle) begin
          if (stop_d) begin
            state_d = IDLE;
          end else begin
            // Rising edge: the pending period takes effect from here.
            state_d = HIGH;
            act_d   = pend_q;
            rem_d   = RW'(pend_high) - gap;
          end
        end else begin
          rem_d   = rem_q - S_R;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      pend_q    <= MIN_PERIOD;
      act_q     <= MIN_PERIOD;
      stop_q    <= 1'b0;
      samples_q <= '0;
      edge_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      stop_q    <= stop_d;
      samples_q <= samples_d;
      edge_q    <= edge_d;
    end
  end

  assign SAMPLES_OUT = samples_q;
  assign EDGE_FLAG   = edge_q;
  assign BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_oversampling_period_generator.sv
module tb_oversampling_period_generator;

  localparam int S = 8;
  localparam int W = 15;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         ENABLE = 1'b0;
  logic [W-1:0] PERIOD_IN = '0;
  logic         PERIOD_WR = 1'b0;
  logic [S-1:0] SAMPLES_OUT;
  logic         EDGE_FLAG;
  logic         BUSY;

  always #5 CLK = ~CLK;

  oversampling_period_generator #(
    .COUNTER_BITS      (12),
    .OVERSAMPLING_BITS (3)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ENABLE      (ENABLE),
    .PERIOD_IN   (PERIOD_IN),
    .PERIOD_WR   (PERIOD_WR),
    .SAMPLES_OUT (SAMPLES_OUT),
    .EDGE_FLAG   (EDGE_FLAG),
    .BUSY        (BUSY)
  );

  typedef struct packed {
    logic [S-1:0] word;
    logic         edge_f;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Slot-by-slot reference: walks each of the S slots of a word individually.
  int   m_state;   // 0 idle, 1 high, 2 low
  int   m_rem;
  int   m_pend;
  int   m_act;
  bit   m_stop;
  bit   m_prev_msb;

  task automatic model_step(input bit rst, input bit en, input bit wr, input int pin);
    exp_t         e;
    logic [S-1:0] w;
    w = '0;
    if (rst) begin
      m_state = 0; m_rem = 0; m_pend = 2 * S; m_act = 2 * S;
      m_stop = 0; m_prev_msb = 0;
    end else begin
      if (m_state == 0) begin
        m_stop = 0;
        if (en) begin
          m_state = 1; m_act = m_pend; m_rem = m_act / 2;
        end
      end else begin
        if (!en) m_stop = 1;
        else if (m_state == 2) m_stop = 0;
        for (int i = 0; i < S; i++) begin
          if (m_state != 0) begin
            w[i] = (m_state == 1);
            m_rem--;
            if (m_rem == 0) begin
              if (m_state == 1) begin
                m_state = 2; m_rem = m_act - m_act / 2;
              end else if (m_stop) begin
                m_state = 0;
              end else begin
                m_state = 1; m_act = m_pend; m_rem = m_act / 2;
              end
            end
          end
        end
      end
      if (wr) m_pend = (pin < 2 * S) ? 2 * S : pin;
    end
    e.word   = w;
    e.edge_f = w[0] & ~m_prev_msb;
    for (int i = 0; i < S - 1; i++) if (!w[i] && w[i+1]) e.edge_f = 1'b1;
    e.busy   = (m_state != 0);
    m_prev_msb = w[S-1];
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, predict, then compare the registered outputs after the edge.
  task automatic cycle(input bit rst, input bit en, input bit wr, input int pin);
    exp_t e;
    RESET     = rst;
    ENABLE    = en;
    PERIOD_WR = wr;
    PERIOD_IN = W'(pin);
    model_step(rst, en, wr, pin);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    n_assert++;
    assert (SAMPLES_OUT === e.word) else begin
      n_fail++; $error("FAIL samples t=%0t got %h exp %h", $time, SAMPLES_OUT, e.word);
    end
    n_assert++;
    assert (EDGE_FLAG === e.edge_f) else begin
      n_fail++; $error("FAIL edge_flag t=%0t got %b exp %b", $time, EDGE_FLAG, e.edge_f);
    end
    n_assert++;
    assert (BUSY === e.busy) else begin
      n_fail++; $error("FAIL busy t=%0t got %b exp %b", $time, BUSY, e.busy);
    end
  endtask

  // Hand-derived expectations for directed segments.
  task automatic expect_now(input string tag, input logic [S-1:0] w, input logic ef, input logic b);
    n_assert++;
    assert (SAMPLES_OUT === w && EDGE_FLAG === ef && BUSY === b) else begin
      n_fail++;
      $error("FAIL %s got %h/%b/%b exp %h/%b/%b", tag, SAMPLES_OUT, EDGE_FLAG, BUSY, w, ef, b);
    end
  endtask

  logic [S-1:0] p32_words [4];
  logic [S-1:0] p20_words [5];

  initial begin
    p32_words[0] = 8'hFF; p32_words[1] = 8'hFF; p32_words[2] = 8'h00; p32_words[3] = 8'h00;
    p20_words[0] = 8'hFF; p20_words[1] = 8'h03; p20_words[2] = 8'hF0;
    p20_words[3] = 8'h3F; p20_words[4] = 8'h00;

    // Reset state.
    cycle(1, 0, 0, 0);
    expect_now("reset", 8'h00, 1'b0, 1'b0);
    cycle(1, 0, 0, 0);

    // P=32 programmed while idle, then started.
    cycle(0, 0, 1, 32);
    cycle(0, 0, 0, 0);
    expect_now("idle_after_wr", 8'h00, 1'b0, 1'b0);
    cycle(0, 1, 0, 0);
    expect_now("start_word", 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 0, 0);
      expect_now("p32", p32_words[k % 4], (k % 4) == 0, 1'b1);
    end

    // Stop requested mid-HIGH: low half completes, then idle with no extra edge.
    cycle(0, 1, 0, 0);
    expect_now("p32_pre_stop", 8'hFF, 1'b1, 1'b1);
    cycle(0, 0, 0, 0);
    expect_now("stop_high", 8'hFF, 1'b0, 1'b1);
    cycle(0, 0, 0, 0);
    expect_now("stop_low1", 8'h00, 1'b0, 1'b1);
    cycle(0, 0, 0, 0);
    expect_now("stop_low2", 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0);
      expect_now("stopped", 8'h00, 1'b0, 1'b0);
    end

    // P=20: 10 high / 10 low slots, pattern repeats every 5 words.
    cycle(0, 0, 1, 20);
    cycle(0, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 0, 0);
      expect_now("p20", p20_words[k % 5], (k % 5) == 0 || (k % 5) == 2, 1'b1);
    end

    // P=17 (odd: high 8, low 9), then P=5 clamped to 16.
    cycle(0, 1, 1, 17);
    for (int k = 0; k < 40; k++) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 5);
    for (int k = 0; k < 20; k++) cycle(0, 1, 0, 0);

    // P=40 written while the P=16 wave is running.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 40);
    for (int k = 0; k < 30; k++) cycle(0, 1, 0, 0);

    // Randomised writes (incl. writes coinciding with rising edges) and enable toggling.
    for (int k = 0; k < 300; k++) begin
      cycle(0, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 70));
    end

    // Reset mid-LOW of P=32, then stays idle without ENABLE.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    expect_now("pre_reset_low", 8'h00, 1'b0, 1'b1);
    cycle(1, 1, 0, 0);
    expect_now("reset_mid_low", 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0);
      expect_now("post_reset_idle", 8'h00, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
